// File: rtl/ahb_decoder_mux_pkg.sv
// Shared AHB encodings and data-phase select codes for the decoder/mux slice.
// dsel codes: NONE and DEF are fixed, slave i is encoded as i+2.
package ahb_decoder_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // Four bits cover NONE, DEF and up to eight mapped slaves
  localparam int DSEL_W = 4;
  localparam logic [DSEL_W-1:0] DSEL_NONE = 4'd0;
  localparam logic [DSEL_W-1:0] DSEL_DEF  = 4'd1;

  // Timeout abort sequencing: the two cycles of an AHB ERROR response
  typedef enum logic [1:0] {
    TO_NORMAL,
    TO_ERR1,
    TO_ERR2
  } to_state_e;

  function automatic logic [DSEL_W-1:0] dsel_slave(input int idx);
    return DSEL_W'(idx + 2);
  endfunction

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the AHB master/slave fabric and the decoder/mux.
// 'master' is the fabric view (master address, slave responses);
// 'slave' is the decoder/mux view.
interface ahb_decoder_mux_if #(
  parameter int NUM_SLV = 4
) ();

  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic [NUM_SLV-1:0]   HSEL_S;
  logic                 HSELDEF;
  logic [32*NUM_SLV-1:0] HRDATA_S;
  logic [NUM_SLV-1:0]   HREADYOUT_S;
  logic [2*NUM_SLV-1:0] HRESP_S;
  logic [31:0]          HRDATADEF;
  logic                 HREADYDEF;
  logic [1:0]           HRESPDEF;
  logic                 HREADY;
  logic [1:0]           HRESP;
  logic [31:0]          HRDATA;
  logic                 TIMEOUT_IRQ;

  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
           HRDATADEF, HREADYDEF, HRESPDEF,
    input  HSEL_S, HSELDEF, HREADY, HRESP, HRDATA, TIMEOUT_IRQ
  );

  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
           HRDATADEF, HREADYDEF, HRESPDEF,
    output HSEL_S, HSELDEF, HREADY, HRESP, HRDATA, TIMEOUT_IRQ
  );

endinterface

// File: rtl/ahb_decoder_mux_timeout_ctrl.sv
// Wait-state watchdog for the decoder/mux. Counts consecutive wait states of
// the selected slave and, at the limit, replaces the slave response with a
// two-cycle ERROR so the master is never stuck. Only instantiated when
// AHB_DECODER_TIMEOUT_EN is defined.
module ahb_timeout_ctrl
  import ahb_decoder_mux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       active,
  input  logic       sel_ready,
  output logic       ovr_en,
  output logic       ovr_ready,
  output logic [1:0] ovr_resp,
  output logic       irq
);

  to_state_e        state, state_nxt;
  logic [CNT_W-1:0] wcnt;
  logic             waiting;

  assign waiting = active & ~sel_ready;

  // State register for the abort sequence
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= TO_NORMAL;
    else          state <= state_nxt;
  end

  // Wait-state counter; restarts on any ready cycle and while aborting
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                            wcnt <= '0;
    else if (state != TO_NORMAL || !waiting) wcnt <= '0;
    else                                     wcnt <= wcnt + 1'b1;
  end

  // Next state and override outputs; a slave that turns ready on the limit cycle wins
  always_comb begin
    state_nxt = state;
    ovr_en    = 1'b0;
    ovr_ready = 1'b1;
    ovr_resp  = HRESP_OKAY;
    irq       = 1'b0;
    case (state)
      TO_NORMAL: begin
        if (waiting && wcnt == CNT_W'(TIMEOUT_CYCLES - 1)) state_nxt = TO_ERR1;
      end
      TO_ERR1: begin
        state_nxt = TO_ERR2;
        ovr_en    = 1'b1;
        ovr_ready = 1'b0;
        ovr_resp  = HRESP_ERROR;
        irq       = 1'b1;
      end
      TO_ERR2: begin
        state_nxt = TO_NORMAL;
        ovr_en    = 1'b1;
        ovr_ready = 1'b1;
        ovr_resp  = HRESP_ERROR;
      end
      default: state_nxt = TO_NORMAL;
    endcase
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB layer address decoder and slave response multiplexer.
// Address-phase HADDR is decoded to one-hot selects (lowest matching slave
// wins, unmapped goes to the default slave); the decode is registered as dsel
// on HREADY and steers the data-phase response back to the master.
// Optional feature macro: AHB_DECODER_TIMEOUT_EN adds a wait-state watchdog
// that aborts a stalled transfer with an ERROR response and pulses TIMEOUT_IRQ.
module ahb_decoder_mux
  import ahb_decoder_mux_pkg::*;
#(
  parameter int           NUM_SLV        = 4,
  parameter logic [255:0] SLV_BASE       = {8{32'h0000_0000}},
  parameter logic [255:0] SLV_MASK       = {8{32'hF000_0000}},
  parameter int           TIMEOUT_CYCLES = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_decoder_mux_if.slave bus
);

  logic [NUM_SLV-1:0] match;
  logic [NUM_SLV-1:0] hsel;
  logic [DSEL_W-1:0]  dsel_dec;
  logic [DSEL_W-1:0]  dsel;
  logic               sel_ready;
  logic [1:0]         sel_resp;
  logic [31:0]        sel_rdata;
  logic               hready;
  logic [1:0]         hresp;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_match
    assign match[i] = ((bus.HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
  end

  // Priority decode: scanning downwards lets the lowest matching index win
  always_comb begin
    hsel     = '0;
    dsel_dec = DSEL_DEF;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hsel     = '0;
        hsel[i]  = 1'b1;
        dsel_dec = dsel_slave(i);
      end
    end
  end

  assign bus.HSEL_S  = hsel;
  assign bus.HSELDEF = ~|match;

  // Data-phase select; holds through wait states, reset aborts the data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    dsel <= DSEL_NONE;
    else if (hready) dsel <= dsel_dec;
  end

  // Response mux; with no transfer in flight the bus reads as ready/OKAY/zero
  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = HRESP_OKAY;
    sel_rdata = '0;
    if (dsel == DSEL_DEF) begin
      sel_ready = bus.HREADYDEF;
      sel_resp  = bus.HRESPDEF;
      sel_rdata = bus.HRDATADEF;
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel == dsel_slave(i)) begin
        sel_ready = bus.HREADYOUT_S[i];
        sel_resp  = bus.HRESP_S[2*i +: 2];
        sel_rdata = bus.HRDATA_S[32*i +: 32];
      end
    end
  end

`ifdef AHB_DECODER_TIMEOUT_EN
  logic       dsel_active;
  logic       ovr_en;
  logic       ovr_ready;
  logic [1:0] ovr_resp;
  logic       to_irq;

  assign dsel_active = (dsel != DSEL_NONE);

  ahb_timeout_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .active    (dsel_active),
    .sel_ready (sel_ready),
    .ovr_en    (ovr_en),
    .ovr_ready (ovr_ready),
    .ovr_resp  (ovr_resp),
    .irq       (to_irq)
  );

  assign hready          = ovr_en ? ovr_ready : sel_ready;
  assign hresp           = ovr_en ? ovr_resp  : sel_resp;
  assign bus.TIMEOUT_IRQ = to_irq;
`else
  assign hready          = sel_ready;
  assign hresp           = sel_resp;
  assign bus.TIMEOUT_IRQ = 1'b0;
`endif

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = sel_rdata;

endmodule
